// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths,
// sequencer state encoding and the per-requester request record.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  // IDLE picks a winner; ACCESS drives the RAM; CAPTURE sees ram_dout; ACK pulses.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_e;

  // One outstanding request as presented by a requester.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick. On a tie the port that did not win last time
// wins; a lone request always wins. Purely combinational.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  // Winner is port 1 when it asks alone, or on a tie when port 0 won last.
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 && req1) ? ~last : req1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for a single-port synchronous
// RAM. Each granted request walks IDLE -> ACCESS -> CAPTURE -> ACK, so one
// access completes every four cycles. All outputs come from registers.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_wr_q, ram_wr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              pick_valid;
  logic              pick_port;

  rr_arb2 u_rr_arb2 (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_port)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    op_we_d    = op_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wr_d   = 1'b0;          // write strobe only ever lasts the ACCESS cycle
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_port;
          last_d     = pick_port;
          op_we_d    = pick_port ? we1 : we0;
          ram_addr_d = pick_port ? addr1 : addr0;
          ram_din_d  = pick_port ? wdata1 : wdata0;
          ram_wr_d   = pick_port ? we1 : we0;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // RAM commits the write or registers the read at the end of this cycle.
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!op_we_q) begin
          if (grant_q) rdata1_d = ram_dout;
          else         rdata0_d = ram_dout;
        end
        if (grant_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;        // port 0 wins the first tie
      op_we_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_wr_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      op_we_q    <= op_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_wr_q   <= ram_wr_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = (state_q != ST_IDLE);
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_wr   = ram_wr_q;

endmodule
